// File: rtl/fifo_write_logic.sv
// Write-side pointer, full flag and fill-level controller for the async FIFO.
// Optional sticky overflow flag (port wovf) is built when WFIFO_OVERFLOW_EN is defined.
//
// state  | meaning
// W_OPEN | at least one free slot, writes accepted
// W_FULL | all 2^PTR_SZ slots occupied, writes dropped
module fifo_write_logic #(
  parameter int PTR_SZ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   wq2_raddr,
  output logic              wfull,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
`ifdef WFIFO_OVERFLOW_EN
  output logic              wovf,
`endif
  output logic [PTR_SZ:0]   wlevel
);

  typedef enum logic {
    W_OPEN = 1'b0,
    W_FULL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_SZ:0]   wbin_q, wbin_d;
  logic [PTR_SZ:0]   wgray_q, wgray_d;
  logic [PTR_SZ:0]   wlevel_q, wlevel_d;
  logic [PTR_SZ:0]   full_cmp;
  logic [PTR_SZ:0]   rbin;

  function automatic logic [PTR_SZ:0] gray2bin(input logic [PTR_SZ:0] g);
    logic [PTR_SZ:0] b;
    b[PTR_SZ] = g[PTR_SZ];
    for (int i = PTR_SZ - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wfull      = (state_q == W_FULL);
  assign waddr      = wbin_q[PTR_SZ-1:0];
  assign waddr_gray = wgray_q;
  assign wlevel     = wlevel_q;

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  assign full_cmp = {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]};
  assign rbin     = gray2bin(wq2_raddr);

  always_comb begin
    write_en = rst & winc & ~wfull;
    wbin_d   = wbin_q + {{PTR_SZ{1'b0}}, write_en};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin;
    state_d  = state_q;
    case (state_q)
      W_OPEN:  if (wgray_d == full_cmp) state_d = W_FULL;
      W_FULL:  if (wgray_d != full_cmp) state_d = W_OPEN;
      default: state_d = W_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= W_OPEN;
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
    end else begin
      state_q  <= state_d;
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
    end
  end

`ifdef WFIFO_OVERFLOW_EN
  logic wovf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wovf_q <= 1'b0;
    end else if (winc && wfull) begin
      wovf_q <= 1'b1;
    end
  end

  assign wovf = wovf_q;
`endif

endmodule

// File: tb/tb_fifo_write_logic.sv
// Bench for fifo_write_logic (PTR_SZ=2): directed vector table plus randomized
// traffic checked against an occupancy-count reference model.
module tb_fifo_write_logic;

  localparam int PTR_SZ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              winc;
  logic [PTR_SZ:0]   wq2_raddr;
  logic              wfull;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ:0]   waddr_gray;
  logic [PTR_SZ:0]   wlevel;
  logic              ovf_act;

  fifo_write_logic #(.PTR_SZ(PTR_SZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .winc       (winc),
    .wq2_raddr  (wq2_raddr),
    .wfull      (wfull),
    .write_en   (write_en),
    .waddr      (waddr),
    .waddr_gray (waddr_gray),
`ifdef WFIFO_OVERFLOW_EN
    .wovf       (ovf_act),
`endif
    .wlevel     (wlevel)
  );

`ifndef WFIFO_OVERFLOW_EN
  assign ovf_act = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: total words written and read pointer position, mod 8.
  int m_wr   = 0;
  int m_full = 0;
  int m_ovf  = 0;
  int m_lvl  = 0;

  // Values sampled around the last cycle.
  logic            pre_we;
  logic [1:0]      pre_wa;
  logic            exp_pre_we;
  logic [1:0]      exp_pre_wa;

  typedef struct {
    logic       r;
    logic       w;
    logic [2:0] rg;
    logic       chk_pre;
    logic       we;
    logic [1:0] wa;
    logic [2:0] g;
    logic       f;
    logic [2:0] l;
    logic       ovf;
  } vec_t;

  function automatic int gray_idx(input logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (((i ^ (i >> 1)) & 7) == int'(g)) return i;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [2:0] rg);
    int rd;
    @(negedge clk);
    rst = r; winc = w; wq2_raddr = rg;
    #1;
    exp_pre_we = r & w & (m_full == 0);
    exp_pre_wa = 2'(m_wr % 4);
    pre_we = write_en;
    pre_wa = waddr;
    @(posedge clk);
    #1;
    if (!r) begin
      m_wr = 0; m_full = 0; m_ovf = 0; m_lvl = 0;
    end else begin
      if (w && m_full != 0) m_ovf = 1;
      m_wr  = (m_wr + (exp_pre_we ? 1 : 0)) % 8;
      rd    = gray_idx(rg);
      m_lvl = (m_wr - rd + 8) % 8;
      m_full = (m_lvl == 4) ? 1 : 0;
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [2:0] rg, logic cp, logic we,
                              logic [1:0] wa, logic [2:0] g, logic f, logic [2:0] l,
                              logic ovf);
    vec_t v;
    v.r = r; v.w = w; v.rg = rg; v.chk_pre = cp; v.we = we; v.wa = wa;
    v.g = g; v.f = f; v.l = l; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    int rd;
    logic r, w;
    rst = 1'b0; winc = 1'b0; wq2_raddr = '0;

    // reset with winc high
    vecs.push_back(mk(0,1,0, 0, 0,0, 0,0,0, 0));
    vecs.push_back(mk(0,1,0, 1, 0,0, 0,0,0, 0));
    // fill
    vecs.push_back(mk(1,1,0, 1, 1,0, 1,0,1, 0));
    vecs.push_back(mk(1,1,0, 1, 1,1, 3,0,2, 0));
    vecs.push_back(mk(1,1,0, 1, 1,2, 2,0,3, 0));
    vecs.push_back(mk(1,1,0, 1, 1,3, 6,1,4, 0));
    // overrun
    vecs.push_back(mk(1,1,0, 1, 0,0, 6,1,4, 1));
    vecs.push_back(mk(1,1,0, 1, 0,0, 6,1,4, 1));
    vecs.push_back(mk(1,1,0, 1, 0,0, 6,1,4, 1));
    // release and refill
    vecs.push_back(mk(1,1,1, 1, 0,0, 6,0,3, 1));
    vecs.push_back(mk(1,1,1, 1, 1,0, 7,1,4, 1));
    // wrap: each read step releases, next edge refills
    vecs.push_back(mk(1,1,3, 1, 0,1, 7,0,3, 1));
    vecs.push_back(mk(1,1,3, 1, 1,1, 5,1,4, 1));
    vecs.push_back(mk(1,1,2, 1, 0,2, 5,0,3, 1));
    vecs.push_back(mk(1,1,2, 1, 1,2, 4,1,4, 1));
    vecs.push_back(mk(1,1,6, 1, 0,3, 4,0,3, 1));
    vecs.push_back(mk(1,1,6, 1, 1,3, 0,1,4, 1));
    vecs.push_back(mk(1,1,7, 1, 0,0, 0,0,3, 1));
    vecs.push_back(mk(1,1,7, 1, 1,0, 1,1,4, 1));
    vecs.push_back(mk(1,1,5, 1, 0,1, 1,0,3, 1));
    vecs.push_back(mk(1,1,5, 1, 1,1, 3,1,4, 1));
    vecs.push_back(mk(1,1,4, 1, 0,2, 3,0,3, 1));
    vecs.push_back(mk(1,1,4, 1, 1,2, 2,1,4, 1));
    vecs.push_back(mk(1,1,0, 1, 0,3, 2,0,3, 1));
    vecs.push_back(mk(1,1,0, 1, 1,3, 6,1,4, 1));
    // reset while full, then first write lands at slot 0
    vecs.push_back(mk(0,1,0, 1, 0,0, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 1, 1,0, 1,0,1, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].w, vecs[i].rg);
      check($sformatf("v%0d write_en", i), int'(pre_we), int'(vecs[i].we));
      if (vecs[i].chk_pre)
        check($sformatf("v%0d waddr", i), int'(pre_wa), int'(vecs[i].wa));
      check($sformatf("v%0d waddr_gray", i), int'(waddr_gray), int'(vecs[i].g));
      check($sformatf("v%0d wfull", i), int'(wfull), int'(vecs[i].f));
      check($sformatf("v%0d wlevel", i), int'(wlevel), int'(vecs[i].l));
`ifdef WFIFO_OVERFLOW_EN
      check($sformatf("v%0d wovf", i), int'(ovf_act), int'(vecs[i].ovf));
`endif
    end

    // Randomized traffic; read pointer advances one Gray step only behind the writer.
    rd = gray_idx(wq2_raddr);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) != 0);
      w = ($urandom_range(0, 9) < 7);
      if (!r) rd = 0;
      else if (rd != m_wr && $urandom_range(0, 2) == 0) rd = (rd + 1) % 8;
      cycle(r, w, 3'((rd ^ (rd >> 1)) & 7));
      check("rnd write_en", int'(pre_we), int'(exp_pre_we));
      check("rnd waddr", int'(pre_wa), int'(exp_pre_wa));
      check("rnd waddr_gray", int'(waddr_gray), (m_wr ^ (m_wr >> 1)) & 7);
      check("rnd wfull", int'(wfull), m_full);
      check("rnd wlevel", int'(wlevel), m_lvl);
`ifdef WFIFO_OVERFLOW_EN
      check("rnd wovf", int'(ovf_act), m_ovf);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_logic.md
Name: fifo_write_logic

Overview:
Write-side pointer and flag controller for the async FIFO. It is the counterpart of the read-side logic.
- Accepts write requests in the write clock domain.
- Produces the RAM write enable and write address.
- Exports a Gray-coded write pointer for synchronization into the read domain.
- Derives full status and fill level from the read pointer after that pointer has been synchronized into the write domain.
- All 2^PTR_SZ RAM locations are usable. Full detection uses PTR_SZ+1-bit wrap-extended pointers, so no slot is left empty.

Parameters:
- PTR_SZ, 2, RAM address width. FIFO depth = 2^PTR_SZ. Legal values: PTR_SZ >= 2.

Ports:
- clk  input  1  write-domain clock; all logic is on the rising edge.
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- winc  input  1  write request (level); one write per clk cycle while high and not full.
- wq2_raddr  input  PTR_SZ+1  read pointer, Gray-coded, already double-flop synchronized into the clk domain.
- wfull  output  1  FIFO full (registered).
- write_en  output  1  RAM write strobe for this cycle.
- waddr  output  PTR_SZ  RAM write address.
- waddr_gray  output  PTR_SZ+1  Gray-coded write pointer (registered), sent to the read-domain synchronizer.
- wlevel  output  PTR_SZ+1  words stored as seen from the write side; range 0..2^PTR_SZ.

Behaviour:
- Reset: rst==0 at a rising edge sets the following, regardless of winc:
  - wbin = 0, waddr_gray = 0, wfull = 0, wlevel = 0, state = W_OPEN.
  - write_en is forced to 0 combinationally while rst==0.
- Internal binary pointer wbin is PTR_SZ+1 bits and wraps modulo 2^(PTR_SZ+1). waddr = wbin[PTR_SZ-1:0].
- write_en = rst & winc & ~wfull (combinational). The RAM captures data at waddr on the same edge.
- Next-pointer terms:
  - wbin_next = wbin + write_en.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Each edge: wbin <= wbin_next and waddr_gray <= wgray_next.
  - waddr_gray changes by exactly one bit per write.
  - waddr_gray holds when write_en == 0.
- Full compare: full_cmp = {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]}.
- State machine (state drives wfull: wfull = (state == W_FULL)):
  - W_OPEN -> W_FULL when wgray_next == full_cmp. wfull asserts on the same edge that commits the last free slot.
  - W_FULL -> W_OPEN when wgray_next != full_cmp, i.e. one edge after wq2_raddr advances.
  - Otherwise hold.
- Fill level: wlevel <= wbin_next - gray2bin(wq2_raddr), computed modulo 2^(PTR_SZ+1).
  - gray2bin is the prefix XOR from the MSB down.
  - wlevel equals 2^PTR_SZ exactly when wfull is 1.
- Write while full: the request is dropped. No pointer change, no RAM write, no stall memory of the request.
- winc high in the same cycle that wq2_raddr advances while full: write_en = 0 that cycle because wfull is registered. A write is accepted the following cycle.
- wq2_raddr may change at most one Gray step per clk. The block performs no resynchronization and no sanity checking of this input.
- Reset mid-operation (including while full): all outputs return to their reset values at the next edge. Data in flight is discarded.

Optional Feature:
- Macro: WFIFO_OVERFLOW_EN.
- Defined:
  - Adds output port wovf (1 bit), registered and sticky.
  - wovf is set on the first edge where winc==1 && wfull==1.
  - wovf is cleared only by reset (rst==0).
  - wovf has no effect on pointer behaviour.
- Not defined: the port and its logic are absent. Dropped writes are silent.

Test Plan:
All scenarios use PTR_SZ=2 (depth 4).
1. Reset: rst=0 for 2 edges with winc=1 -> write_en=0, waddr=0, waddr_gray=0, wfull=0, wlevel=0 (and wovf=0) after each edge.
2. Fill:
   - Stimulus: wq2_raddr=0, winc=1 for 4 edges.
   - write_en=1 with waddr 0,1,2,3 before edges 1..4.
   - waddr_gray 1,3,2,6 after edges 1..4.
   - After edge 4: wfull=1, wlevel=4.
3. Overrun:
   - Stimulus: continue winc=1 for 3 more edges.
   - write_en=0; waddr_gray stays 6; waddr stays 0; wlevel stays 4.
   - With WFIFO_OVERFLOW_EN: wovf=1 after the first of these edges and stays 1.
4. Release and refill:
   - Stimulus: wq2_raddr 0->1 with winc=1 held.
   - Edge a: wfull=0, wlevel=3, no write.
   - Edge b: write at waddr 0, waddr_gray=7, wfull=1, wlevel=4.
5. Wrap:
   - Stimulus: advance wq2_raddr in Gray order 1,3,2,6,7,5,4,0, each followed by one accepted write.
   - waddr_gray steps 5,4,0,1,3,2,6.
   - wbin wraps 7->0 with no spurious wfull.
   - wlevel stays at 3/4 as expected.
6. Reset while full: from the state at the end of scenario 2, drive rst=0 for 1 edge -> wfull=0, waddr_gray=0, wlevel=0. With rst=1 and winc=1, the next write goes to waddr 0.
